// File: rtl/picorv32_wb_master_pkg.sv
// picorv32_wb_master_pkg: shared state encoding, parameter defaults and helpers
package picorv32_wb_master_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } state_t;
    localparam int          DEF_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEF_ERR_RDATA      = 32'h0000_0000;
    function automatic logic [3:0] bus_sel(input logic [3:0] wstrb);
        return (|wstrb) ? wstrb : 4'hF;
    endfunction
endpackage

// File: rtl/picorv32_wb_master_timeout_counter.sv
// wb_timeout_counter: saturating cycle counter; expired marks the LIMIT-th counted cycle
module wb_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            cnt <= '0;
        else if (i_clear)
            cnt <= '0;
        else if (i_enable && cnt != '1)
            cnt <= cnt + 1'b1;
    end
    // cnt holds the number of cycles already spent, so the current cycle is cnt+1
    assign o_expired = cnt >= W'(LIMIT - 1);
endmodule

// File: rtl/picorv32_wb_master.sv
// picorv32_wb_master: bridges the picorv32 native memory port to a pipelined
// Wishbone master with registered outputs, error handling and a transfer timeout.
module picorv32_wb_master
    import picorv32_wb_master_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_mem_valid,
    input  logic        i_mem_instr,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_wstrb,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic        o_bus_err,
    output logic        o_bus_err_sticky
);
    state_t      state, state_n;
    logic        cyc_n, stb_n, we_n, ready_n, err_n, sticky_n;
    logic [31:0] addr_n, data_n, rdata_n;
    logic [3:0]  sel_n;
    logic        expired, live, resp_ok, resp_err, done_err;
    logic        unused_instr;

    assign unused_instr = i_mem_instr;

    wb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (state == S_IDLE && i_mem_valid),
        .i_enable  (state == S_REQ || state == S_WAIT),
        .o_expired (expired)
    );

    // responses only count once the strobe has been accepted (no stall) or in WAIT
    assign live     = (state == S_WAIT) || !i_wb_stall;
    assign resp_ok  = live && i_wb_ack && !i_wb_err;
    assign resp_err = live && i_wb_err;
    assign done_err = resp_err || (expired && !resp_ok);

    always_comb begin
        state_n  = state;
        cyc_n    = o_wb_cyc;
        stb_n    = o_wb_stb;
        we_n     = o_wb_we;
        addr_n   = o_wb_addr;
        data_n   = o_wb_data;
        sel_n    = o_wb_sel;
        rdata_n  = o_mem_rdata;
        ready_n  = 1'b0;
        err_n    = 1'b0;
        sticky_n = o_bus_err_sticky;
        case (state)
            S_IDLE: if (i_mem_valid) begin
                state_n = S_REQ;
                cyc_n   = 1'b1;
                stb_n   = 1'b1;
                we_n    = |i_mem_wstrb;
                addr_n  = i_mem_addr;
                data_n  = i_mem_wdata;
                sel_n   = bus_sel(i_mem_wstrb);
            end
            S_REQ, S_WAIT: if (resp_ok || done_err) begin
                state_n  = S_RESP;
                cyc_n    = 1'b0;
                stb_n    = 1'b0;
                ready_n  = 1'b1;
                err_n    = done_err;
                sticky_n = o_bus_err_sticky || done_err;
                rdata_n  = done_err ? ERR_RDATA : (o_wb_we ? o_mem_rdata : i_wb_data);
            end else if (state == S_REQ && !i_wb_stall) begin
                state_n = S_WAIT;
                stb_n   = 1'b0;
            end
            S_RESP: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= S_IDLE;
            o_wb_cyc         <= 1'b0;
            o_wb_stb         <= 1'b0;
            o_wb_we          <= 1'b0;
            o_wb_addr        <= '0;
            o_wb_data        <= '0;
            o_wb_sel         <= '0;
            o_mem_rdata      <= '0;
            o_mem_ready      <= 1'b0;
            o_bus_err        <= 1'b0;
            o_bus_err_sticky <= 1'b0;
        end else begin
            state            <= state_n;
            o_wb_cyc         <= cyc_n;
            o_wb_stb         <= stb_n;
            o_wb_we          <= we_n;
            o_wb_addr        <= addr_n;
            o_wb_data        <= data_n;
            o_wb_sel         <= sel_n;
            o_mem_rdata      <= rdata_n;
            o_mem_ready      <= ready_n;
            o_bus_err        <= err_n;
            o_bus_err_sticky <= sticky_n;
        end
    end
endmodule

// File: tb/tb_picorv32_wb_master.sv
// tb_picorv32_wb_master: directed transfers against a scripted Wishbone slave
module tb_picorv32_wb_master;
    localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid = 1'b0, instr = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rd_data = '0;
    logic [3:0]  wstrb = '0;
    logic        stall = 1'b0, ack_drv = 1'b0, err_drv = 1'b0, zl_ack = 1'b0;
    logic        ready, cyc, stb, we, bus_err, sticky, wb_ack;
    logic [31:0] rdata, wb_addr, wb_data;
    logic [3:0]  sel;
    int          n_chk = 0, n_fail = 0;
    int          stb_cnt = 0, cyc_cnt = 0, rdy_cnt = 0, cyc_rise = 0;
    logic        cyc_prev = 1'b0;

    // zero-latency slave acks combinationally on an accepted strobe
    assign wb_ack = ack_drv | (zl_ack & stb & ~stall);

    picorv32_wb_master #(.TIMEOUT_CYCLES(8), .ERR_RDATA(ERRV)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_mem_valid      (valid),
        .i_mem_instr      (instr),
        .i_mem_addr       (addr),
        .i_mem_wdata      (wdata),
        .i_mem_wstrb      (wstrb),
        .o_mem_ready      (ready),
        .o_mem_rdata      (rdata),
        .o_wb_cyc         (cyc),
        .o_wb_stb         (stb),
        .o_wb_we          (we),
        .o_wb_addr        (wb_addr),
        .o_wb_data        (wb_data),
        .o_wb_sel         (sel),
        .i_wb_stall       (stall),
        .i_wb_ack         (wb_ack),
        .i_wb_err         (err_drv),
        .i_wb_data        (rd_data),
        .o_bus_err        (bus_err),
        .o_bus_err_sticky (sticky)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stb) stb_cnt <= stb_cnt + 1;
        if (cyc) cyc_cnt <= cyc_cnt + 1;
        if (ready) rdy_cnt <= rdy_cnt + 1;
        if (cyc && !cyc_prev) cyc_rise <= cyc_rise + 1;
        cyc_prev <= cyc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, c, r, cr, n;
        logic [31:0] exp_d [3];
        repeat (2) tick();
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_ready", ready, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_sticky", sticky, 0);
        rst_n = 1'b1;
        tick();

        // zero-stall read, ack with strobe
        addr = 32'h0000_0100; wstrb = 4'h0; rd_data = 32'h1234_5678; zl_ack = 1'b1; valid = 1'b1;
        tick();
        chk("rd_cyc", cyc, 1);
        chk("rd_stb", stb, 1);
        chk("rd_sel", sel, 4'hF);
        chk("rd_we", we, 0);
        chk("rd_addr", wb_addr, 32'h0000_0100);
        chk("rd_ready_early", ready, 0);
        tick();
        chk("rd_ready", ready, 1);
        chk("rd_rdata", rdata, 32'h1234_5678);
        chk("rd_cyc_drop", cyc, 0);
        valid = 1'b0;
        tick();
        chk("rd_ready_once", ready, 0);

        // stalled write, ack two cycles after acceptance; ack during stall is ignored
        zl_ack = 1'b0; stall = 1'b1; addr = 32'h0000_0200; wdata = 32'hA5A5_0F0F; wstrb = 4'b0011;
        valid = 1'b1; s = stb_cnt; r = rdy_cnt;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("wr_stb_stall", stb, 1);
            chk("wr_addr_stable", wb_addr, 32'h0000_0200);
            chk("wr_data_stable", wb_data, 32'hA5A5_0F0F);
            chk("wr_sel", sel, 4'b0011);
            chk("wr_we", we, 1);
            ack_drv = (i == 1);
            tick();
            ack_drv = 1'b0;
        end
        chk("wr_ack_ignored", ready, 0);
        stall = 1'b0;
        chk("wr_stb_last", stb, 1);
        tick();
        chk("wr_wait_stb", stb, 0);
        chk("wr_wait_cyc", cyc, 1);
        tick();
        chk("wr_wait_cyc2", cyc, 1);
        ack_drv = 1'b1;
        tick();
        ack_drv = 1'b0;
        chk("wr_ready", ready, 1);
        chk("wr_rdata_kept", rdata, 32'h1234_5678);
        chk("wr_cyc_drop", cyc, 0);
        valid = 1'b0;
        tick();
        chk("wr_stb_cycles", stb_cnt - s, 4);
        chk("wr_ready_pulses", rdy_cnt - r, 1);
        chk("wr_sticky_clear", sticky, 0);

        // err and ack together: err wins
        addr = 32'h0000_0300; wstrb = 4'h0; valid = 1'b1;
        tick();
        ack_drv = 1'b1; err_drv = 1'b1;
        tick();
        ack_drv = 1'b0; err_drv = 1'b0;
        chk("err_ready", ready, 1);
        chk("err_rdata", rdata, ERRV);
        chk("err_pulse", bus_err, 1);
        chk("err_sticky", sticky, 1);
        valid = 1'b0;
        tick();
        chk("err_pulse_end", bus_err, 0);
        chk("err_sticky_hold", sticky, 1);

        // reset while waiting for ack
        addr = 32'h0000_0500; valid = 1'b1; r = rdy_cnt;
        tick();
        tick();
        chk("rw_wait_cyc", cyc, 1);
        chk("rw_wait_stb", stb, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_cyc_async", cyc, 0);
        chk("rw_sticky", sticky, 0);
        chk("rw_rdata", rdata, 0);
        chk("rw_addr", wb_addr, 0);
        chk("rw_sel", sel, 0);
        valid = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) tick();
        chk("rw_no_ready", rdy_cnt - r, 0);
        addr = 32'h0000_0010; rd_data = 32'hCAFE_F00D; zl_ack = 1'b1; valid = 1'b1;
        tick();
        chk("rw_next_addr", wb_addr, 32'h0000_0010);
        tick();
        chk("rw_next_ready", ready, 1);
        chk("rw_next_rdata", rdata, 32'hCAFE_F00D);
        valid = 1'b0;
        tick();

        // silent slave: timeout after 8 cycles of cyc
        zl_ack = 1'b0; addr = 32'h0000_0600; valid = 1'b1; c = cyc_cnt;
        tick();
        for (int k = 0; k < 20 && !ready; k++) tick();
        chk("to_ready", ready, 1);
        chk("to_cyc_cycles", cyc_cnt - c, 8);
        chk("to_rdata", rdata, ERRV);
        chk("to_pulse", bus_err, 1);
        chk("to_sticky", sticky, 1);
        valid = 1'b0;
        tick();

        // back-to-back reads with valid held high
        exp_d[0] = 32'h1111_0001; exp_d[1] = 32'h2222_0002; exp_d[2] = 32'h3333_0003;
        zl_ack = 1'b1; instr = 1'b1; addr = 32'h0000_0700; rd_data = exp_d[0]; valid = 1'b1;
        r = rdy_cnt; cr = cyc_rise; n = 0;
        for (int k = 0; k < 30 && n < 3; k++) begin
            tick();
            if (ready) begin
                chk("b2b_rdata", rdata, exp_d[n]);
                n++;
                if (n < 3) begin
                    addr = addr + 32'd4;
                    rd_data = exp_d[n];
                end else
                    valid = 1'b0;
            end
        end
        tick();
        chk("b2b_done", n, 3);
        chk("b2b_ready_pulses", rdy_cnt - r, 3);
        chk("b2b_cyc_rises", cyc_rise - cr, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
